// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush scheduler: FSM states and the
// register-control bundle driven to the PC and the four pipeline registers.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    StRun,
    StDwait
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_clr;
    logic id_ex_clr;
    logic mem_wb_clr;
  } ctrl_t;

  // Driven while rst is high: nothing loads, nothing clears.
  localparam ctrl_t CtrlReset = '0;

  localparam ctrl_t CtrlRun = '{
    pc_en:      1'b1,
    if_id_en:   1'b1,
    id_ex_en:   1'b1,
    ex_mem_en:  1'b1,
    mem_wb_en:  1'b1,
    if_id_clr:  1'b0,
    id_ex_clr:  1'b0,
    mem_wb_clr: 1'b0
  };

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and register-control outputs between the pipeline datapath
// (master) and the stall/flush scheduler (slave).
interface pipeline_ctrl_if #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 32
);
  logic [REG_ADDR_WIDTH-1:0] id_rs1;
  logic [REG_ADDR_WIDTH-1:0] id_rs2;
  logic                      id_uses_rs1;
  logic                      id_uses_rs2;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      ex_mem_read;
  logic                      ex_pc_src;
  logic                      imem_ready;
  logic                      mem_req;
  logic                      mem_ack;

  logic                      pc_en;
  logic                      if_id_en;
  logic                      id_ex_en;
  logic                      ex_mem_en;
  logic                      mem_wb_en;
  logic                      if_id_clr;
  logic                      id_ex_clr;
  logic                      mem_wb_clr;
  logic [CNT_WIDTH-1:0]      stall_cycles;
  logic [CNT_WIDTH-1:0]      flush_count;
  logic                      mem_timeout;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read, ex_pc_src,
           imem_ready, mem_req, mem_ack,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_clr, id_ex_clr,
           mem_wb_clr, stall_cycles, flush_count, mem_timeout
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read, ex_pc_src,
           imem_ready, mem_req, mem_ack,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_clr, id_ex_clr,
           mem_wb_clr, stall_cycles, flush_count, mem_timeout
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use compare: a load in EX whose destination is read by the ID instruction.
module hazard_detect #(
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
  input  logic                      id_uses_rs1_i,
  input  logic                      id_uses_rs2_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_i,
  input  logic                      ex_mem_read_i,
  output logic                      load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit    = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
    rs2_hit    = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    load_use_o = ex_mem_read_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: priority mux over data freeze,
// branch flush, load-use and fetch wait, plus perf counters and a dmem watchdog.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned DMEM_TIMEOUT   = 256
) (
  input logic           clk,
  input logic           rst,
  pipeline_ctrl_if.slave bus
);

  localparam int unsigned WaitW = $clog2(DMEM_TIMEOUT + 1);

  logic                 load_use;
  logic                 freeze;
  ctrl_t                ctrl;
  state_e               state_q, state_d;
  logic [WaitW-1:0]     wait_q, wait_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic [CNT_WIDTH-1:0] flush_q, flush_d;
  logic                 timeout_q, timeout_d;

  hazard_detect #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_hazard_detect (
    .id_rs1_i      (bus.id_rs1),
    .id_rs2_i      (bus.id_rs2),
    .id_uses_rs1_i (bus.id_uses_rs1),
    .id_uses_rs2_i (bus.id_uses_rs2),
    .ex_rd_i       (bus.ex_rd),
    .ex_mem_read_i (bus.ex_mem_read),
    .load_use_o    (load_use)
  );

  // A DWAIT cycle with mem_ack high is not a freeze: it runs as a normal RUN cycle.
  always_comb begin
    freeze = !bus.mem_ack && ((state_q == StDwait) || bus.mem_req);
    ctrl   = CtrlRun;
    if (rst) begin
      ctrl = CtrlReset;
    end else if (freeze) begin
      ctrl.pc_en      = 1'b0;
      ctrl.if_id_en   = 1'b0;
      ctrl.id_ex_en   = 1'b0;
      ctrl.ex_mem_en  = 1'b0;
      ctrl.mem_wb_clr = 1'b1;
    end else if (bus.ex_pc_src) begin
      ctrl.if_id_clr = 1'b1;
      ctrl.id_ex_clr = 1'b1;
    end else if (load_use) begin
      ctrl.pc_en     = 1'b0;
      ctrl.if_id_en  = 1'b0;
      ctrl.id_ex_clr = 1'b1;
    end else if (!bus.imem_ready) begin
      ctrl.pc_en     = 1'b0;
      ctrl.if_id_clr = 1'b1;
    end
  end

  always_comb begin
    state_d = freeze ? StDwait : StRun;
    wait_d  = wait_q;
    if (state_q == StDwait) begin
      if (wait_q != WaitW'(DMEM_TIMEOUT)) begin
        wait_d = wait_q + WaitW'(1);
      end
    end else if (freeze) begin
      wait_d = '0;
    end
    timeout_d = timeout_q || (wait_d == WaitW'(DMEM_TIMEOUT));

    stall_d = stall_q;
    if (!ctrl.pc_en && (stall_q != '1)) begin
      stall_d = stall_q + CNT_WIDTH'(1);
    end
    flush_d = flush_q;
    if (!freeze && bus.ex_pc_src && (flush_q != '1)) begin
      flush_d = flush_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StRun;
      wait_q    <= '0;
      stall_q   <= '0;
      flush_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.pc_en        = ctrl.pc_en;
  assign bus.if_id_en     = ctrl.if_id_en;
  assign bus.id_ex_en     = ctrl.id_ex_en;
  assign bus.ex_mem_en    = ctrl.ex_mem_en;
  assign bus.mem_wb_en    = ctrl.mem_wb_en;
  assign bus.if_id_clr    = ctrl.if_id_clr;
  assign bus.id_ex_clr    = ctrl.id_ex_clr;
  assign bus.mem_wb_clr   = ctrl.mem_wb_clr;
  assign bus.stall_cycles = stall_q;
  assign bus.flush_count  = flush_q;
  assign bus.mem_timeout  = timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus randomized traffic against a
// cycle-level reference model. A second instance with 3-bit counters shares the stimulus.
module tb_pipeline_ctrl;

  localparam int unsigned TO = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  // Reference model state
  int m_stall;
  int m_flush;
  int m_wait;
  bit m_dwait;
  bit m_timeout;

  pipeline_ctrl_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) bus_a ();
  pipeline_ctrl_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(3))  bus_b ();

  pipeline_ctrl #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(32), .DMEM_TIMEOUT(TO)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  pipeline_ctrl #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(3), .DMEM_TIMEOUT(TO)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  assign bus_b.id_rs1      = bus_a.id_rs1;
  assign bus_b.id_rs2      = bus_a.id_rs2;
  assign bus_b.id_uses_rs1 = bus_a.id_uses_rs1;
  assign bus_b.id_uses_rs2 = bus_a.id_uses_rs2;
  assign bus_b.ex_rd       = bus_a.ex_rd;
  assign bus_b.ex_mem_read = bus_a.ex_mem_read;
  assign bus_b.ex_pc_src   = bus_a.ex_pc_src;
  assign bus_b.imem_ready  = bus_a.imem_ready;
  assign bus_b.mem_req     = bus_a.mem_req;
  assign bus_b.mem_ack     = bus_a.mem_ack;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] obs_a();
    return {bus_a.pc_en, bus_a.if_id_en, bus_a.id_ex_en, bus_a.ex_mem_en, bus_a.mem_wb_en,
            bus_a.if_id_clr, bus_a.id_ex_clr, bus_a.mem_wb_clr};
  endfunction

  function automatic logic [7:0] obs_b();
    return {bus_b.pc_en, bus_b.if_id_en, bus_b.id_ex_en, bus_b.ex_mem_en, bus_b.mem_wb_en,
            bus_b.if_id_clr, bus_b.id_ex_clr, bus_b.mem_wb_clr};
  endfunction

  function automatic bit model_frozen();
    return !bus_a.mem_ack && (m_dwait || bus_a.mem_req);
  endfunction

  function automatic bit model_load_use();
    bit hit1;
    bit hit2;
    hit1 = bus_a.id_uses_rs1 && (bus_a.id_rs1 == bus_a.ex_rd);
    hit2 = bus_a.id_uses_rs2 && (bus_a.id_rs2 == bus_a.ex_rd);
    return bus_a.ex_mem_read && (bus_a.ex_rd != 0) && (hit1 || hit2);
  endfunction

  // Bit order: pc, if_id, id_ex, ex_mem, mem_wb enables; if_id, id_ex, mem_wb clears.
  function automatic logic [7:0] model_ctrl();
    if (rst)               return 8'b00000_000;
    if (model_frozen())    return 8'b00001_001;
    if (bus_a.ex_pc_src)   return 8'b11111_110;
    if (model_load_use())  return 8'b00111_010;
    if (!bus_a.imem_ready) return 8'b01111_100;
    return 8'b11111_000;
  endfunction

  function automatic logic [2:0] sat3(input int v);
    return (v > 7) ? 3'd7 : 3'(v);
  endfunction

  task automatic model_reset();
    m_stall   = 0;
    m_flush   = 0;
    m_wait    = 0;
    m_dwait   = 0;
    m_timeout = 0;
  endtask

  // Advance one clock; the model commits what this cycle's inputs imply.
  task automatic step();
    logic [7:0] c;
    bit         fz;
    c  = model_ctrl();
    fz = model_frozen();
    @(posedge clk);
    if (!rst) begin
      if (!c[7]) m_stall++;
      if (!fz && bus_a.ex_pc_src) m_flush++;
      if (m_dwait) begin
        if (m_wait < TO) m_wait++;
        if (m_wait >= TO) m_timeout = 1;
      end else if (fz) begin
        m_wait = 0;
      end
      m_dwait = fz;
    end
    #1;
  endtask

  task automatic drive_idle();
    bus_a.id_rs1      = '0;
    bus_a.id_rs2      = '0;
    bus_a.id_uses_rs1 = 1'b0;
    bus_a.id_uses_rs2 = 1'b0;
    bus_a.ex_rd       = '0;
    bus_a.ex_mem_read = 1'b0;
    bus_a.ex_pc_src   = 1'b0;
    bus_a.imem_ready  = 1'b1;
    bus_a.mem_req     = 1'b0;
    bus_a.mem_ack     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    drive_idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    drive_idle();
    #1;
    n_checks++;
    if (obs_a() !== 8'h00) begin
      n_errors++; $display("FAIL reset_ctrl: got %b expected %b", obs_a(), 8'h00);
    end
    n_checks++;
    if (bus_a.stall_cycles !== 32'd0) begin
      n_errors++; $display("FAIL reset_stall: got %0d expected 0", bus_a.stall_cycles);
    end
    n_checks++;
    if (bus_a.flush_count !== 32'd0) begin
      n_errors++; $display("FAIL reset_flush: got %0d expected 0", bus_a.flush_count);
    end
    n_checks++;
    if (bus_a.mem_timeout !== 1'b0) begin
      n_errors++; $display("FAIL reset_timeout: got %b expected 0", bus_a.mem_timeout);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (obs_a() !== 8'b11111_000) begin
      n_errors++; $display("FAIL reset_release_run: got %b expected %b", obs_a(), 8'b11111_000);
    end
    step();
  endtask

  task automatic test_load_use();
    do_reset();
    bus_a.ex_mem_read = 1'b1;
    bus_a.ex_rd       = 5'd5;
    bus_a.id_rs2      = 5'd5;
    bus_a.id_uses_rs2 = 1'b1;
    #1;
    n_checks++;
    if (obs_a() !== 8'b00111_010) begin
      n_errors++; $display("FAIL load_use_ctrl: got %b expected %b", obs_a(), 8'b00111_010);
    end
    step();
    n_checks++;
    if (bus_a.stall_cycles !== 32'd1) begin
      n_errors++; $display("FAIL load_use_stall: got %0d expected 1", bus_a.stall_cycles);
    end
    bus_a.ex_rd  = 5'd0;
    bus_a.id_rs2 = 5'd0;
    #1;
    n_checks++;
    if (obs_a() !== 8'b11111_000) begin
      n_errors++; $display("FAIL load_use_x0: got %b expected %b", obs_a(), 8'b11111_000);
    end
    step();
    n_checks++;
    if (bus_a.stall_cycles !== 32'd1) begin
      n_errors++; $display("FAIL load_use_x0_stall: got %0d expected 1", bus_a.stall_cycles);
    end
  endtask

  task automatic test_branch();
    do_reset();
    bus_a.ex_pc_src   = 1'b1;
    bus_a.ex_mem_read = 1'b1;
    bus_a.ex_rd       = 5'd7;
    bus_a.id_rs1      = 5'd7;
    bus_a.id_uses_rs1 = 1'b1;
    bus_a.imem_ready  = 1'b0;
    #1;
    n_checks++;
    if (obs_a() !== 8'b11111_110) begin
      n_errors++; $display("FAIL branch_ctrl: got %b expected %b", obs_a(), 8'b11111_110);
    end
    step();
    n_checks++;
    if (bus_a.flush_count !== 32'd1) begin
      n_errors++; $display("FAIL branch_flush: got %0d expected 1", bus_a.flush_count);
    end
    n_checks++;
    if (bus_a.stall_cycles !== 32'd0) begin
      n_errors++; $display("FAIL branch_stall: got %0d expected 0", bus_a.stall_cycles);
    end
  endtask

  task automatic test_data_wait();
    do_reset();
    bus_a.mem_req   = 1'b1;
    bus_a.mem_ack   = 1'b0;
    bus_a.ex_pc_src = 1'b1;  // must be ignored while frozen
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (obs_a() !== 8'b00001_001) begin
        n_errors++; $display("FAIL dwait_freeze%0d: got %b expected %b", i, obs_a(), 8'b00001_001);
      end
      step();
    end
    bus_a.ex_pc_src = 1'b0;
    bus_a.mem_ack   = 1'b1;
    #1;
    n_checks++;
    if (obs_a() !== 8'b11111_000) begin
      n_errors++; $display("FAIL dwait_ack: got %b expected %b", obs_a(), 8'b11111_000);
    end
    step();
    bus_a.mem_req = 1'b0;
    bus_a.mem_ack = 1'b0;
    #1;
    n_checks++;
    if (obs_a() !== 8'b11111_000) begin
      n_errors++; $display("FAIL dwait_back_to_run: got %b expected %b", obs_a(), 8'b11111_000);
    end
    n_checks++;
    if (bus_a.stall_cycles !== 32'd3) begin
      n_errors++; $display("FAIL dwait_stall: got %0d expected 3", bus_a.stall_cycles);
    end
    n_checks++;
    if (bus_a.flush_count !== 32'd0) begin
      n_errors++; $display("FAIL dwait_flush: got %0d expected 0", bus_a.flush_count);
    end
  endtask

  // Entry edge plus four DWAIT cycles: the flag appears after the fifth edge.
  task automatic test_timeout();
    do_reset();
    bus_a.mem_req = 1'b1;
    bus_a.mem_ack = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      n_checks++;
      if (bus_a.mem_timeout !== (k >= 5)) begin
        n_errors++;
        $display("FAIL timeout_edge%0d: got %b expected %b", k, bus_a.mem_timeout, (k >= 5));
      end
    end
    bus_a.mem_ack = 1'b1;
    step();
    bus_a.mem_req = 1'b0;
    bus_a.mem_ack = 1'b0;
    step();
    n_checks++;
    if (bus_a.mem_timeout !== 1'b1) begin
      n_errors++; $display("FAIL timeout_sticky: got %b expected 1", bus_a.mem_timeout);
    end
  endtask

  task automatic test_reset_mid_dwait();
    bus_a.mem_req = 1'b1;
    bus_a.mem_ack = 1'b0;
    step();
    step();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (bus_a.stall_cycles !== 32'd0 || bus_a.flush_count !== 32'd0) begin
      n_errors++;
      $display("FAIL midreset_counters: got %0d/%0d expected 0/0",
               bus_a.stall_cycles, bus_a.flush_count);
    end
    n_checks++;
    if (bus_a.mem_timeout !== 1'b0) begin
      n_errors++; $display("FAIL midreset_timeout: got %b expected 0", bus_a.mem_timeout);
    end
    n_checks++;
    if (obs_a() !== 8'h00) begin
      n_errors++; $display("FAIL midreset_ctrl: got %b expected %b", obs_a(), 8'h00);
    end
    drive_idle();
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (obs_a() !== 8'b11111_000) begin
      n_errors++; $display("FAIL midreset_release: got %b expected %b", obs_a(), 8'b11111_000);
    end
    step();
  endtask

  task automatic test_saturation();
    do_reset();
    bus_a.imem_ready = 1'b0;
    for (int i = 0; i < 10; i++) step();
    n_checks++;
    if (bus_b.stall_cycles !== 3'd7) begin
      n_errors++; $display("FAIL sat_stall3: got %0d expected 7", bus_b.stall_cycles);
    end
    n_checks++;
    if (bus_a.stall_cycles !== 32'd10) begin
      n_errors++; $display("FAIL sat_stall32: got %0d expected 10", bus_a.stall_cycles);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_c;
    int         ack_div;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      ack_div = (i < 300) ? 2 : 8;
      rst = ($urandom_range(0, 49) == 0);
      if (rst) model_reset();
      bus_a.id_rs1      = 5'($urandom_range(0, 3));
      bus_a.id_rs2      = 5'($urandom_range(0, 3));
      bus_a.ex_rd       = 5'($urandom_range(0, 3));
      bus_a.id_uses_rs1 = 1'($urandom_range(0, 1));
      bus_a.id_uses_rs2 = 1'($urandom_range(0, 1));
      bus_a.ex_mem_read = 1'($urandom_range(0, 1));
      bus_a.ex_pc_src   = ($urandom_range(0, 3) == 0);
      bus_a.imem_ready  = ($urandom_range(0, 3) != 0);
      bus_a.mem_req     = ($urandom_range(0, 2) == 0);
      bus_a.mem_ack     = ($urandom_range(0, ack_div - 1) == 0);
      #1;
      exp_c = model_ctrl();
      n_checks++;
      if (obs_a() !== exp_c) begin
        n_errors++; $display("FAIL rand_ctrl_a[%0d]: got %b expected %b", i, obs_a(), exp_c);
      end
      n_checks++;
      if (obs_b() !== exp_c) begin
        n_errors++; $display("FAIL rand_ctrl_b[%0d]: got %b expected %b", i, obs_b(), exp_c);
      end
      n_checks++;
      if (bus_a.stall_cycles !== 32'(m_stall) || bus_a.flush_count !== 32'(m_flush)) begin
        n_errors++;
        $display("FAIL rand_cnt_a[%0d]: got %0d/%0d expected %0d/%0d", i,
                 bus_a.stall_cycles, bus_a.flush_count, m_stall, m_flush);
      end
      n_checks++;
      if (bus_b.stall_cycles !== sat3(m_stall) || bus_b.flush_count !== sat3(m_flush)) begin
        n_errors++;
        $display("FAIL rand_cnt_b[%0d]: got %0d/%0d expected %0d/%0d", i,
                 bus_b.stall_cycles, bus_b.flush_count, sat3(m_stall), sat3(m_flush));
      end
      n_checks++;
      if (bus_a.mem_timeout !== m_timeout || bus_b.mem_timeout !== m_timeout) begin
        n_errors++;
        $display("FAIL rand_timeout[%0d]: got %b/%b expected %b", i,
                 bus_a.mem_timeout, bus_b.mem_timeout, m_timeout);
      end
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    model_reset();
    drive_idle();
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_data_wait();
    test_timeout();
    test_reset_mid_dwait();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
